branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

Sequences branch resolution for the pipelined RISC-V core around the EX-stage branch comparator. It predicts taken/not-taken at fetch using a 2-bit branch history table (BHT), and takes the comparator's taken result at EX. On a mispredict it issues a PC redirect and flushes IF/ID and ID/EX. It stalls the front end while branch operands are not ready or while fetch has not accepted a redirect.

## Interface
Parameters:
- BHT_ENTRIES, 16 — number of BHT entries; power of two, minimum 2; index is pc[log2(BHT_ENTRIES)+1:2].
- CNT_W, 16 — width of the statistics counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- if_pc  in  32  PC of the instruction in fetch.
- if_pred_taken  out  1  combinational prediction for if_pc (BHT counter MSB).
- ex_valid  in  1  valid instruction in EX.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_jump  in  1  EX instruction is JAL/JALR.
- ex_pc  in  32  PC of the EX instruction.
- ex_target  in  32  computed branch/jump target.
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- ex_ops_ready  in  1  forwarded rs1/rs2 are valid this cycle.
- cmp_taken  in  1  taken result from the branch comparator.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  32  redirect target.
- redirect_ready  in  1  fetch accepts the redirect this cycle.
- stall_req  out  1  freeze PC, IF/ID and ID/EX.
- flush_if_id  out  1  clear IF/ID at the next edge.
- flush_id_ex  out  1  clear ID/EX at the next edge.
- branch_cnt  out  CNT_W  resolved conditional branches (wraps).
- mispred_cnt  out  CNT_W  mispredictions, branches and jumps (wraps).

## Operation
A control-flow op is ex_valid & (ex_branch | ex_jump). If both ex_branch and ex_jump are high, the op is treated as a jump.

The FSM has three states:
- IDLE
  - Control-flow op with !ex_ops_ready: assert stall_req combinationally; next state WAIT_OPS.
  - Control-flow op with ex_ops_ready: resolve in this cycle.
- WAIT_OPS
  - stall_req stays high while !ex_ops_ready.
  - When ex_ops_ready rises: resolve in that cycle; stall_req drops that cycle unless a redirect is pending.
- HOLD
  - A redirect was not accepted. Drive the latched redirect_pc with redirect_valid=1, stall_req=1, flush_if_id=1 and flush_id_ex=1 every cycle.
  - On redirect_ready: next state IDLE.
  - ex_valid is ignored in this state.

Resolve:
- actual = ex_jump ? 1 : cmp_taken.
- mispredict = actual != ex_pred_taken.
- On mispredict, combinationally in the same cycle:
  - redirect_valid=1, flush_if_id=1, flush_id_ex=1.
  - redirect_pc = actual ? ex_target : ex_pc + 4. The addition wraps modulo 2^32.
  - If redirect_ready=0: latch redirect_pc, assert stall_req, next state HOLD. Otherwise next state IDLE.
- For a conditional branch only:
  - Update the BHT entry at ex_pc.
  - Increment branch_cnt.
- Jumps never update the BHT.
- Every mispredict increments mispred_cnt.
- Counters wrap at 2^CNT_W.

BHT:
- Each entry is a 2-bit saturating counter: increment on taken (cap 2'b11), decrement on not-taken (floor 2'b00).
- Prediction is the counter MSB.
- The read is combinational. A same-cycle write to the same index returns the old value; the new value is visible from the next cycle.

## Timing
- Reset values:
  - State IDLE.
  - All BHT entries 2'b01 (weakly not-taken).
  - Counters 0.
  - redirect_valid, stall_req and both flush outputs 0.
  - redirect_pc 0.
  - if_pred_taken 0.
- Resolution to redirect/flush has zero-cycle latency. The BHT and counters update at the resolving clock edge.
- Redirect handshake: a transfer occurs on a cycle where redirect_valid & redirect_ready. While in HOLD, redirect_pc stays stable until that transfer.
- A correctly predicted resolve produces no redirect, no flush and no stall.
- An asynchronous reset in WAIT_OPS or HOLD returns to IDLE immediately. All outputs go to their reset values.

## Structure
- Shared package branch_pkg:
  - State enum bp_state_t {IDLE, WAIT_OPS, HOLD}.
  - Constants BHT_INIT=2'b01 and PC_STEP=32'd4.
- Sub-module branch_history_table:
  - Parameter ENTRIES.
  - Ports: read index, read prediction, write enable, write index, taken.
  - Holds the counter array and the saturating-update logic.
- The controller FSM, redirect latch and statistics counters live in branch_resolve_ctrl.

## Test plan
- After reset, if_pc=0x100 -> if_pred_taken=0. Branch at 0x100 with cmp_taken=1, ex_pred_taken=0, redirect_ready=1 -> same-cycle redirect_pc=ex_target and both flushes high; branch_cnt=1, mispred_cnt=1; entry [0] becomes 2'b10, so if_pred_taken=1 for 0x100 the next cycle.
- Branch at 0x200 with ex_pred_taken=1, cmp_taken=0 -> redirect_pc=0x204. Then cmp_taken=0 with ex_pred_taken=0 -> no redirect, mispred_cnt unchanged.
- ex_ops_ready=0 for 3 cycles -> stall_req high 3 cycles, state WAIT_OPS. On the 4th cycle ops ready and correctly predicted -> stall_req 0, branch_cnt +1.
- Mispredict with redirect_ready=0 for 2 cycles -> HOLD. redirect_pc stays stable with redirect_valid, stall_req and flushes high; an ex_valid pulse during HOLD is ignored; return to IDLE after the ready cycle.
- JAL with ex_pred_taken=0 -> redirect to ex_target, mispred_cnt +1, BHT and branch_cnt unchanged. Branch at ex_pc=0xFFFFFFFC, not-taken, predicted taken -> redirect_pc=0x00000000.
- Assert rst_n low mid-HOLD -> all outputs 0 asynchronously. After release, the BHT predicts not-taken for any PC.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution controller and its BHT.
package branch_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_OPS, HOLD} bp_state_t;

    localparam logic [1:0]  BHT_INIT = 2'b01;
    localparam logic [31:0] PC_STEP  = 32'd4;
endpackage

// File: rtl/branch_history_table.sv
// 2-bit saturating-counter branch history table with a combinational read port.
module branch_history_table
    import branch_pkg::*;
#(
    parameter int ENTRIES = 16,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_pred,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             taken
);
    logic [1:0] cnt [ENTRIES];

    // Read sees the pre-edge value on a same-cycle write to the same index.
    assign rd_pred = cnt[rd_idx][1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) cnt[i] <= BHT_INIT;
        end else if (wr_en) begin
            if (taken && cnt[wr_idx] != 2'b11)
                cnt[wr_idx] <= cnt[wr_idx] + 2'd1;
            else if (!taken && cnt[wr_idx] != 2'b00)
                cnt[wr_idx] <= cnt[wr_idx] - 2'd1;
        end
    end
endmodule

// File: rtl/branch_resolve_ctrl.sv
// EX-stage branch resolution: prediction lookup, mispredict redirect/flush,
// operand-wait stall, redirect hold until fetch accepts, and statistics.
module branch_resolve_ctrl
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic [31:0]      ex_pc,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic             ex_ops_ready,
    input  logic             cmp_taken,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    input  logic             redirect_ready,
    output logic             stall_req,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    bp_state_t   state, next_state;
    logic [31:0] hold_pc;
    logic        cf_op, actual, mispred, resolve, is_branch;
    logic [31:0] fix_pc;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[31:IDX_W+2], if_pc[1:0]};

    // Gating with rst_n keeps every output at its reset value while reset is held.
    assign cf_op     = rst_n & ex_valid & (ex_branch | ex_jump);
    assign is_branch = ex_branch & ~ex_jump;
    assign actual    = ex_jump | cmp_taken;
    assign mispred   = actual != ex_pred_taken;
    assign fix_pc    = actual ? ex_target : ex_pc + PC_STEP;

    always_comb begin
        next_state     = state;
        resolve        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        stall_req      = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        case (state)
            HOLD: begin
                redirect_valid = 1'b1;
                redirect_pc    = hold_pc;
                stall_req      = 1'b1;
                flush_if_id    = 1'b1;
                flush_id_ex    = 1'b1;
                if (redirect_ready) next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
                if (cf_op && !ex_ops_ready) begin
                    stall_req  = 1'b1;
                    next_state = WAIT_OPS;
                end else if (cf_op) begin
                    resolve = 1'b1;
                    if (mispred) begin
                        redirect_valid = 1'b1;
                        redirect_pc    = fix_pc;
                        flush_if_id    = 1'b1;
                        flush_id_ex    = 1'b1;
                        if (!redirect_ready) begin
                            stall_req  = 1'b1;
                            next_state = HOLD;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_pc     <= 32'd0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            state <= next_state;
            if (resolve && mispred && !redirect_ready) hold_pc <= fix_pc;
            if (resolve && is_branch) branch_cnt <= branch_cnt + 1'b1;
            if (resolve && mispred)   mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

    branch_history_table #(.ENTRIES(BHT_ENTRIES)) u_bht (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_idx  (if_pc[IDX_W+1:2]),
        .rd_pred (if_pred_taken),
        .wr_en   (resolve & is_branch),
        .wr_idx  (ex_pc[IDX_W+1:2]),
        .taken   (actual)
    );
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl: inputs change on the falling edge,
// combinational outputs are sampled 1ns later, state updates at the rising edge.
module tb_branch_resolve_ctrl;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid, ex_branch, ex_jump, ex_pred_taken, ex_ops_ready, cmp_taken;
    logic [31:0] ex_pc, ex_target;
    logic        redirect_valid, redirect_ready, stall_req, flush_if_id, flush_id_ex;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt, mispred_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.BHT_ENTRIES(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_pc(ex_pc),
        .ex_target(ex_target), .ex_pred_taken(ex_pred_taken), .ex_ops_ready(ex_ops_ready),
        .cmp_taken(cmp_taken), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .stall_req(stall_req), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Redirect/stall/flush bundle: {redirect_valid, stall_req, flush_if_id, flush_id_ex}
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        chk(tag, {28'd0, redirect_valid, stall_req, flush_if_id, flush_id_ex}, {28'd0, exp});
    endtask

    task automatic drive(input logic v, input logic br, input logic jp, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pred, input logic cmp,
                         input logic rdy, input logic rr);
        ex_valid = v; ex_branch = br; ex_jump = jp; ex_pc = pc; ex_target = tgt;
        ex_pred_taken = pred; cmp_taken = cmp; ex_ops_ready = rdy; redirect_ready = rr;
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        if_pc = 32'h100;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk_ctl("reset_ctl", 4'b0000);
        chk("reset_rpc", redirect_pc, 32'h0);
        chk("reset_pred", {31'd0, if_pred_taken}, 32'd0);
        chk("reset_bcnt", {16'd0, branch_cnt}, 32'd0);
        chk("reset_mcnt", {16'd0, mispred_cnt}, 32'd0);
        step; rst_n = 1'b1;

        // Mispredicted taken branch at 0x100, fetch accepts immediately
        step; drive(1, 1, 0, 32'h100, 32'h180, 0, 1, 1, 1); #1;
        chk("t1_pred_before", {31'd0, if_pred_taken}, 32'd0);
        chk_ctl("t1_ctl", 4'b1011);
        chk("t1_rpc", redirect_pc, 32'h180);
        step; drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        chk("t1_bcnt", {16'd0, branch_cnt}, 32'd1);
        chk("t1_mcnt", {16'd0, mispred_cnt}, 32'd1);
        chk("t1_pred_after", {31'd0, if_pred_taken}, 32'd1);
        chk_ctl("t1_quiet", 4'b0000);

        // Predicted taken, actually not taken at 0x200 -> fall-through redirect
        step; drive(1, 1, 0, 32'h200, 32'h280, 1, 0, 1, 1); #1;
        chk_ctl("t2_ctl", 4'b1011);
        chk("t2_rpc", redirect_pc, 32'h204);
        step; drive(1, 1, 0, 32'h200, 32'h280, 0, 0, 1, 1); #1;
        chk_ctl("t2_correct_ctl", 4'b0000);
        step; drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        chk("t2_bcnt", {16'd0, branch_cnt}, 32'd3);
        chk("t2_mcnt", {16'd0, mispred_cnt}, 32'd2);

        // Operands late for 3 cycles, then correctly predicted not-taken
        step; drive(1, 1, 0, 32'h208, 32'h280, 0, 0, 0, 1); #1;
        chk_ctl("t3_stall0", 4'b0100);
        step; #1;
        chk_ctl("t3_stall1", 4'b0100);
        chk("t3_state", 32'(dut.state), 32'(WAIT_OPS));
        step; #1;
        chk_ctl("t3_stall2", 4'b0100);
        step; ex_ops_ready = 1'b1; #1;
        chk_ctl("t3_resolve", 4'b0000);
        step; drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        chk("t3_bcnt", {16'd0, branch_cnt}, 32'd4);
        chk("t3_mcnt", {16'd0, mispred_cnt}, 32'd2);
        chk("t3_state_idle", 32'(dut.state), 32'(IDLE));

        // Mispredict while fetch is busy -> HOLD with stable redirect
        step; drive(1, 1, 0, 32'h300, 32'h400, 0, 1, 1, 0); #1;
        chk_ctl("t4_res_ctl", 4'b1111);
        chk("t4_res_rpc", redirect_pc, 32'h400);
        step; drive(1, 1, 0, 32'h500, 32'h600, 1, 0, 1, 0); #1;
        chk("t4_state_hold", 32'(dut.state), 32'(HOLD));
        chk_ctl("t4_hold_ctl", 4'b1111);
        chk("t4_hold_rpc", redirect_pc, 32'h400);
        step; drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        chk_ctl("t4_accept_ctl", 4'b1111);
        chk("t4_accept_rpc", redirect_pc, 32'h400);
        step; #1;
        chk("t4_state_idle", 32'(dut.state), 32'(IDLE));
        chk_ctl("t4_after_ctl", 4'b0000);
        chk("t4_bcnt", {16'd0, branch_cnt}, 32'd5);
        chk("t4_mcnt", {16'd0, mispred_cnt}, 32'd3);

        // JAL predicted not-taken: redirect, no BHT or branch_cnt change
        if_pc = 32'h104;
        step; drive(1, 0, 1, 32'h104, 32'h800, 0, 0, 1, 1); #1;
        chk_ctl("t5_jal_ctl", 4'b1011);
        chk("t5_jal_rpc", redirect_pc, 32'h800);
        step; drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        chk("t5_bcnt", {16'd0, branch_cnt}, 32'd5);
        chk("t5_mcnt", {16'd0, mispred_cnt}, 32'd4);
        chk("t5_pred", {31'd0, if_pred_taken}, 32'd0);

        // Fall-through at top of address space wraps to zero
        step; drive(1, 1, 0, 32'hFFFF_FFFC, 32'h10, 1, 0, 1, 1); #1;
        chk_ctl("t5_wrap_ctl", 4'b1011);
        chk("t5_wrap_rpc", redirect_pc, 32'h0);
        step; drive(0, 0, 0, 0, 0, 0, 0, 0, 1); #1;
        chk("t5_wrap_bcnt", {16'd0, branch_cnt}, 32'd6);
        chk("t5_wrap_mcnt", {16'd0, mispred_cnt}, 32'd5);

        // Enter HOLD (entry 1 trains to weakly taken), then reset asynchronously
        step; drive(1, 1, 0, 32'h104, 32'h900, 0, 1, 1, 0); #1;
        chk("t6_rpc", redirect_pc, 32'h900);
        step; drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("t6_state_hold", 32'(dut.state), 32'(HOLD));
        chk("t6_pred_trained", {31'd0, if_pred_taken}, 32'd1);
        #1 rst_n = 1'b0; #1;
        chk_ctl("t6_rst_ctl", 4'b0000);
        chk("t6_rst_rpc", redirect_pc, 32'h0);
        chk("t6_rst_state", 32'(dut.state), 32'(IDLE));
        chk("t6_rst_bcnt", {16'd0, branch_cnt}, 32'd0);
        chk("t6_rst_mcnt", {16'd0, mispred_cnt}, 32'd0);
        chk("t6_rst_pred", {31'd0, if_pred_taken}, 32'd0);
        step; rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step; if_pc = 32'h100 + 32'(i * 4); #1;
            chk("t6_post_pred", {31'd0, if_pred_taken}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
